// File: rtl/sram_responder_pkg.sv
// Shared types and constants for the SNES-side SRAM responder.
// Optional feature macro: SRAM_MCU_ARB_EN (enables the MCU byte port arbitration).
package sram_responder_pkg;

  localparam int ACCESS_CYCLES_DEF = 4;
  localparam int SYNC_STAGES_DEF   = 3;
  localparam int SRAM_ADDR_W       = 23;
  localparam int DATA_W            = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SNES_RD = 3'd1,
    ST_SNES_WR = 3'd2,
    ST_MCU_RD  = 3'd3,
    ST_MCU_WR  = 3'd4,
    ST_RECOVER = 3'd5
  } state_t;

  // Picks the addressed byte out of a 16-bit SRAM word.
  function automatic logic [DATA_W-1:0] selectByte(input logic [15:0] word, input logic hiByte);
    return hiByte ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/sram_responder_strobe_sync.sv
// Synchronizer and falling-edge detector for one asynchronous active-low SNES strobe.
// Part of sram_responder (optional feature macro: SRAM_MCU_ARB_EN, not used here).
module snes_strobe_sync
  import sram_responder_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_strobe,
  output logic o_sync,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_chain;
  logic [SYNC_STAGES-1:0] r_valid;
  logic                   r_armed;

  // Shift the strobe through the chain; r_valid tracks which stages hold post-reset samples so
  // that a strobe already low during reset never looks like a fresh falling edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chain <= '1;
      r_valid <= '0;
      r_armed <= 1'b0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_strobe};
      r_valid <= {r_valid[SYNC_STAGES-2:0], 1'b1};
      r_armed <= r_valid[SYNC_STAGES-1] & r_chain[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];
  assign o_fall = r_armed & ~r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/sram_responder.sv
// SNES memory-side responder: runs timed cycles on the 16-bit external SRAM for decoded SNES
// reads/writes and, when SRAM_MCU_ARB_EN is defined, slots MCU byte accesses into idle time.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF,
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_snesCs,
  input  logic                   i_snesRd,
  input  logic                   i_snesWr,
  input  logic [23:0]            i_romAddr,
  input  logic                   i_isRom,
  input  logic                   i_isSaveram,
  input  logic [DATA_W-1:0]      i_snesDin,
  output logic [DATA_W-1:0]      o_snesDout,
  output logic                   o_snesDoe,
  input  logic                   i_mcuReq,
  input  logic                   i_mcuWrite,
  input  logic [23:0]            i_mcuAddr,
  input  logic [DATA_W-1:0]      i_mcuWdata,
  output logic [DATA_W-1:0]      o_mcuRdata,
  output logic                   o_mcuAck,
  output logic [SRAM_ADDR_W-1:0] o_sramAddr,
  output logic                   o_sramBheN,
  output logic                   o_sramBleN,
  output logic                   o_sramCeN,
  output logic                   o_sramOeN,
  output logic                   o_sramWeN,
  input  logic [15:0]            i_sramDin,
  output logic [15:0]            o_sramDout,
  output logic                   o_sramDoe
);

  logic w_rdSync;
  logic w_rdFall;
  logic w_unusedWrSync;
  logic w_wrFall;
  logic w_mcuReq;

  state_t r_state;
  state_t w_nextState;
  logic [3:0] r_count;
  logic w_lastCount;
  logic w_startSnesRd;
  logic w_startSnesWr;
  logic w_startMcu;

  logic        r_rdPend;
  logic        r_wrPend;
  logic [23:0] r_rdAddr;
  logic        r_rdHit;
  logic [23:0] r_wrAddr;
  logic [DATA_W-1:0] r_wrData;

  logic [SRAM_ADDR_W-1:0] r_sramAddr;
  logic                   r_byteSel;
  logic [DATA_W-1:0]      r_sramWdata;
  logic [DATA_W-1:0]      r_snesDout;
  logic [DATA_W-1:0]      r_mcuRdata;
  logic                   r_mcuAck;

  logic w_sramCeN;
  logic w_sramOeN;
  logic w_sramWeN;
  logic w_sramBheN;
  logic w_sramBleN;
  logic w_sramDoe;

  snes_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rdSync (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_strobe (i_snesRd),
    .o_sync   (w_rdSync),
    .o_fall   (w_rdFall)
  );

  snes_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wrSync (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_strobe (i_snesWr),
    .o_sync   (w_unusedWrSync),
    .o_fall   (w_wrFall)
  );

`ifdef SRAM_MCU_ARB_EN
  assign w_mcuReq = i_mcuReq;
`else
  logic w_unusedMcuReq;
  assign w_unusedMcuReq = i_mcuReq;
  assign w_mcuReq       = 1'b0;
`endif

  assign w_lastCount = (r_count == 4'(ACCESS_CYCLES - 1));

  // Capture address/data on each detected strobe edge; a later edge of the same direction
  // overwrites an unserviced one, and misses, deselects and ROM writes never raise a request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdPend <= 1'b0;
      r_wrPend <= 1'b0;
      r_rdAddr <= '0;
      r_rdHit  <= 1'b0;
      r_wrAddr <= '0;
      r_wrData <= '0;
    end else begin
      if (w_rdFall) begin
        r_rdAddr <= i_romAddr;
        r_rdHit  <= i_isRom | i_isSaveram;
        r_rdPend <= (i_isRom | i_isSaveram) & ~i_snesCs;
      end else if (w_startSnesRd) begin
        r_rdPend <= 1'b0;
      end
      if (w_wrFall) begin
        r_wrAddr <= i_romAddr;
        r_wrData <= i_snesDin;
        r_wrPend <= i_isSaveram & ~i_snesCs;
      end else if (w_startSnesWr) begin
        r_wrPend <= 1'b0;
      end
    end
  end

  // Next-state selection and SRAM strobe decode for the current state and access count.
  always_comb begin
    w_nextState   = r_state;
    w_startSnesRd = 1'b0;
    w_startSnesWr = 1'b0;
    w_startMcu    = 1'b0;
    w_sramCeN     = 1'b1;
    w_sramOeN     = 1'b1;
    w_sramWeN     = 1'b1;
    w_sramBheN    = 1'b1;
    w_sramBleN    = 1'b1;
    w_sramDoe     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_rdPend) begin
          w_nextState   = ST_SNES_RD;
          w_startSnesRd = 1'b1;
        end else if (r_wrPend) begin
          w_nextState   = ST_SNES_WR;
          w_startSnesWr = 1'b1;
        end else if (w_mcuReq) begin
          w_nextState = i_mcuWrite ? ST_MCU_WR : ST_MCU_RD;
          w_startMcu  = 1'b1;
        end
      end
      ST_SNES_RD, ST_MCU_RD: begin
        w_sramCeN  = 1'b0;
        w_sramOeN  = 1'b0;
        w_sramBheN = 1'b0;
        w_sramBleN = 1'b0;
        if (w_lastCount) w_nextState = ST_RECOVER;
      end
      ST_SNES_WR, ST_MCU_WR: begin
        w_sramCeN  = 1'b0;
        w_sramDoe  = 1'b1;
        w_sramWeN  = (r_count == 4'd0);
        w_sramBleN = r_byteSel;
        w_sramBheN = ~r_byteSel;
        if (w_lastCount) w_nextState = ST_RECOVER;
      end
      ST_RECOVER: w_nextState = ST_IDLE;
      default:    w_nextState = ST_IDLE;
    endcase
  end

  // State register, access counter, per-access address/data latch and read-data return.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_count     <= 4'd0;
      r_sramAddr  <= '0;
      r_byteSel   <= 1'b0;
      r_sramWdata <= '0;
      r_snesDout  <= '0;
      r_mcuRdata  <= '0;
      r_mcuAck    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ST_IDLE || r_state == ST_RECOVER) r_count <= 4'd0;
      else                                            r_count <= r_count + 4'd1;
      if (w_startSnesRd) begin
        r_sramAddr <= r_rdAddr[23:1];
        r_byteSel  <= r_rdAddr[0];
      end else if (w_startSnesWr) begin
        r_sramAddr  <= r_wrAddr[23:1];
        r_byteSel   <= r_wrAddr[0];
        r_sramWdata <= r_wrData;
      end else if (w_startMcu) begin
        r_sramAddr  <= i_mcuAddr[23:1];
        r_byteSel   <= i_mcuAddr[0];
        r_sramWdata <= i_mcuWdata;
      end
      if (r_state == ST_SNES_RD && w_lastCount) r_snesDout <= selectByte(i_sramDin, r_byteSel);
`ifdef SRAM_MCU_ARB_EN
      if (r_state == ST_MCU_RD && w_lastCount) r_mcuRdata <= selectByte(i_sramDin, r_byteSel);
      r_mcuAck <= (r_state == ST_MCU_RD || r_state == ST_MCU_WR) && w_lastCount;
`else
      r_mcuRdata <= '0;
      r_mcuAck   <= 1'b0;
`endif
    end
  end

  assign o_sramAddr = r_sramAddr;
  assign o_sramCeN  = w_sramCeN;
  assign o_sramOeN  = w_sramOeN;
  assign o_sramWeN  = w_sramWeN;
  assign o_sramBheN = w_sramBheN;
  assign o_sramBleN = w_sramBleN;
  assign o_sramDoe  = w_sramDoe;
  assign o_sramDout = {r_sramWdata, r_sramWdata};
  assign o_snesDout = r_snesDout;
  assign o_snesDoe  = ~w_rdSync & ~i_snesCs & r_rdHit;
  assign o_mcuRdata = r_mcuRdata;
  assign o_mcuAck   = r_mcuAck;

endmodule
